io_uart_mmio: RTL and testbench

// - Memory-mapped UART peripheral on the CPU IO bus (io_addr/io_dout/io_we/io_din), downstream of the MEM stage.
// - Stores bytes written by the core in a TX FIFO, serialises them 8N1 on txd, deserialises rxd into an RX FIFO.
// - Returns register reads combinationally on io_din, which the MEM/WB register captures.

---
 rtl/io_uart_mmio_pkg.sv | 18 +
 rtl/uart_fifo.sv | 36 +++
 rtl/io_uart_mmio.sv | 142 ++++++++++++++
 tb/tb_io_uart_mmio.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/io_uart_mmio_pkg.sv
// io_uart_mmio_pkg: register offsets, STATUS bit positions and FSM state types for the MMIO UART
package io_uart_mmio_pkg;
  localparam logic [7:0] A_TXDATA = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_RXDATA = 8'h08;
  localparam logic [7:0] A_RXPOP  = 8'h0C;
  localparam logic [7:0] A_CLRFLG = 8'h10;
  localparam int S_TX_FULL  = 0;
  localparam int S_TX_EMPTY = 1;
  localparam int S_RX_VALID = 2;
  localparam int S_RX_FULL  = 3;
  localparam int S_TX_OVF   = 4;
  localparam int S_RX_OVF   = 5;
  localparam int S_TX_BUSY  = 6;
  localparam int S_RX_FERR  = 7;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with wrap-bit pointers and combinational head read
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic w_push, w_pop;
  assign o_empty = r_wp == r_rp;
  assign o_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
  // a pop frees the slot in the same cycle, so a push on a full FIFO is kept when popping
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop) r_rp <= r_rp + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_din;
endmodule

// File: rtl/io_uart_mmio.sv
// io_uart_mmio: memory-mapped 8N1 UART with TX/RX FIFOs, sticky error flags and RX interrupt
module io_uart_mmio
  import io_uart_mmio_pkg::*;
#(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  output logic [31:0] io_din,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);
  localparam int CW = $clog2(BAUD_DIV) + 1;
  localparam logic [CW-1:0] DIV_M1  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  logic w_tx_wr, w_rx_pop, w_clr, w_unused;
  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic [7:0] w_tx_head, w_rx_head, w_status;
  tx_state_e r_tx_st, w_tx_nst;
  rx_state_e r_rx_st, w_rx_nst;
  logic [CW-1:0] r_tx_cnt, r_rx_cnt;
  logic [2:0] r_tx_bit, r_rx_bit;
  logic [7:0] r_tx_sh, r_rx_sh;
  logic w_tx_tick, w_tx_pop, w_rx_tick, w_rx_half, w_rx_push, w_rx_ferr;
  logic r_rx_s1, r_rx_s2, r_rx_prev;
  logic r_tx_ovf, r_rx_ovf, r_rx_ferr;
  assign w_tx_wr  = io_we && io_addr == A_TXDATA;
  assign w_rx_pop = io_we && io_addr == A_RXPOP;
  assign w_clr    = io_we && io_addr == A_CLRFLG;
  assign w_unused = ^io_dout[31:8];
  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .i_push(w_tx_wr), .i_din(io_dout[7:0]), .i_pop(w_tx_pop),
    .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );
  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .i_push(w_rx_push), .i_din(r_rx_sh), .i_pop(w_rx_pop),
    .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_ovf  <= 1'b0;
      r_rx_ovf  <= 1'b0;
      r_rx_ferr <= 1'b0;
    end else begin
      r_tx_ovf  <= (w_tx_wr && w_tx_full && !w_tx_pop) || (r_tx_ovf && !(w_clr && io_dout[4]));
      r_rx_ovf  <= (w_rx_push && w_rx_full && !w_rx_pop) || (r_rx_ovf && !(w_clr && io_dout[5]));
      r_rx_ferr <= w_rx_ferr || (r_rx_ferr && !(w_clr && io_dout[7]));
    end
  end
  assign w_tx_tick = r_tx_cnt == DIV_M1;
  always_comb begin
    w_tx_nst = r_tx_st;
    w_tx_pop = 1'b0;
    case (r_tx_st)
      TX_IDLE:  if (!w_tx_empty) begin
        w_tx_pop = 1'b1;
        w_tx_nst = TX_START;
      end
      TX_START: if (w_tx_tick) w_tx_nst = TX_DATA;
      TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_nst = TX_STOP;
      TX_STOP:  if (w_tx_tick) begin
        w_tx_pop = !w_tx_empty;
        w_tx_nst = w_tx_empty ? TX_IDLE : TX_START;
      end
      default:  w_tx_nst = TX_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_st  <= TX_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
    end else begin
      r_tx_st  <= w_tx_nst;
      r_tx_cnt <= (w_tx_nst != r_tx_st || w_tx_tick) ? '0 : r_tx_cnt + CW'(1);
      if (r_tx_st == TX_DATA && w_tx_tick) r_tx_bit <= r_tx_bit + 3'd1;
      if (w_tx_pop) r_tx_sh <= w_tx_head;
      else if (r_tx_st == TX_DATA && w_tx_tick) r_tx_sh <= {1'b1, r_tx_sh[7:1]};
    end
  end
  assign txd = r_tx_st == TX_START ? 1'b0 : r_tx_st == TX_DATA ? r_tx_sh[0] : 1'b1;
  assign w_rx_tick = r_rx_cnt == DIV_M1;
  assign w_rx_half = r_rx_cnt == HALF_M1;
  always_comb begin
    w_rx_nst  = r_rx_st;
    w_rx_push = 1'b0;
    w_rx_ferr = 1'b0;
    case (r_rx_st)
      RX_IDLE:  if (r_rx_prev && !r_rx_s2) w_rx_nst = RX_START;
      RX_START: if (w_rx_half) w_rx_nst = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_nst = RX_STOP;
      RX_STOP:  if (w_rx_tick) begin
        w_rx_push = r_rx_s2;
        w_rx_ferr = !r_rx_s2;
        w_rx_nst  = RX_WAIT;
      end
      RX_WAIT:  if (r_rx_s2) w_rx_nst = RX_IDLE;
      default:  w_rx_nst = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_rx_st   <= RX_IDLE;
      r_rx_cnt  <= '0;
      r_rx_bit  <= '0;
      r_rx_sh   <= '0;
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      r_rx_st   <= w_rx_nst;
      r_rx_cnt  <= (w_rx_nst != r_rx_st || w_rx_tick) ? '0 : r_rx_cnt + CW'(1);
      if (r_rx_st == RX_DATA && w_rx_tick) begin
        r_rx_bit <= r_rx_bit + 3'd1;
        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
      end
    end
  end
  always_comb begin
    w_status = '0;
    w_status[S_TX_FULL]  = w_tx_full;
    w_status[S_TX_EMPTY] = w_tx_empty;
    w_status[S_RX_VALID] = !w_rx_empty;
    w_status[S_RX_FULL]  = w_rx_full;
    w_status[S_TX_OVF]   = r_tx_ovf;
    w_status[S_RX_OVF]   = r_rx_ovf;
    w_status[S_TX_BUSY]  = r_tx_st != TX_IDLE;
    w_status[S_RX_FERR]  = r_rx_ferr;
  end
  assign io_din = io_addr == A_STATUS ? {24'h0, w_status} :
                  (io_addr == A_RXDATA && !w_rx_empty) ? {24'h0, w_rx_head} : 32'h0;
  assign irq = !w_rx_empty;
endmodule

// File: tb/tb_io_uart_mmio.sv
// tb_io_uart_mmio: scoreboard bench for the MMIO UART with a serial TX monitor and an RX frame driver
module tb_io_uart_mmio;
  localparam int BD = 4;
  logic clk = 1'b0, rst = 1'b1, io_we = 1'b0, rxd = 1'b1;
  logic [7:0] io_addr = '0;
  logic [31:0] io_dout = '0, io_din;
  logic txd, irq;
  int n_chk = 0, n_err = 0;
  logic [7:0] tx_q[$], rx_q[$];
  bit mon_off = 1'b1;
  always #5 clk = ~clk;
  io_uart_mmio #(.BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
    .io_din(io_din), .rxd(rxd), .txd(txd), .irq(irq)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_addr = a;
    io_dout = d;
    io_we = 1'b1;
    @(posedge clk);
    #1;
    io_we = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    io_addr = a;
    #1;
    d = io_din;
  endtask
  task automatic rx_frame(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    if (stop && rx_q.size() < 4) rx_q.push_back(b);
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      tick(BD);
    end
    rxd = 1'b1;
    tick(6);
  endtask
  task automatic tx_drain(input int lim);
    for (int i = 0; i < lim && tx_q.size() != 0; i++) tick(1);
    check("tx_drain", tx_q.size(), 0);
    tick(2 * BD);
  endtask
  initial begin : mon
    logic [7:0] b;
    bit ok;
    forever begin
      @(negedge txd);
      ok = !mon_off;
      repeat (BD / 2) @(posedge clk);
      #1;
      if (ok) check("tx_start_bit", txd, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(posedge clk);
        #1;
        b[i] = txd;
      end
      repeat (BD) @(posedge clk);
      #1;
      if (ok) begin
        check("tx_stop_bit", txd, 1);
        if (tx_q.size() == 0) check("tx_extra", {24'h0, b}, 32'h100);
        else check("tx_byte", {24'h0, b}, {24'h0, tx_q.pop_front()});
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  initial begin
    logic [31:0] d;
    bit seen_low;
    tick(3);
    rst = 1'b0;
    rd(8'h04, d);
    check("rst_status", d, 32'h02);
    check("rst_txd", txd, 1);
    check("rst_irq", irq, 0);
    mon_off = 1'b0;
    tx_q.push_back(8'hA5);
    wr(8'h00, 32'hA5);
    check("tx_pre", txd, 1);
    tick(1);
    check("tx_latency", txd, 0);
    tick(39);
    rd(8'h04, d);
    check("busy_hold", d[6], 1);
    tick(1);
    rd(8'h04, d);
    check("busy_drop", d[6], 0);
    for (int i = 1; i <= 5; i++) begin
      tx_q.push_back(8'(i * 17));
      wr(8'h00, 32'(i * 17));
    end
    rd(8'h04, d);
    check("tx_full", d[0], 1);
    check("tx_no_ovf", d[4], 0);
    wr(8'h00, 32'h66);
    rd(8'h04, d);
    check("tx_ovf_set", d[4], 1);
    wr(8'h10, 32'h10);
    rd(8'h04, d);
    check("tx_ovf_clr", d[4], 0);
    tx_drain(400);
    rd(8'h04, d);
    check("tx_idle", d[7:0], 32'h02);
    rx_frame(8'h3C, 1'b1);
    check("rx_irq", irq, 1);
    rd(8'h08, d);
    check("rx_data", d, {24'h0, rx_q[0]});
    rd(8'h08, d);
    check("rx_no_pop", d, {24'h0, rx_q[0]});
    wr(8'h0C, 32'h0);
    void'(rx_q.pop_front());
    rd(8'h04, d);
    check("rx_valid_clr", d[2], 0);
    rd(8'h08, d);
    check("rx_empty_read", d, 0);
    check("rx_irq_clr", irq, 0);
    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(20);
    rd(8'h04, d);
    check("glitch", d & 32'hA4, 0);
    rx_frame(8'h5A, 1'b0);
    rd(8'h04, d);
    check("rx_ferr", d[7], 1);
    check("ferr_no_push", d[2], 0);
    wr(8'h10, 32'h80);
    rd(8'h04, d);
    check("rx_ferr_clr", d[7], 0);
    for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b1);
    rd(8'h04, d);
    check("rx_ovf", d[5], 1);
    check("rx_full", d[3], 1);
    check("rx_irq_full", irq, 1);
    wr(8'h0C, 32'h0);
    void'(rx_q.pop_front());
    tx_q.push_back(8'h77);
    wr(8'h00, 32'h77);
    rd(8'h04, d);
    check("rx_not_full", d[3], 0);
    while (rx_q.size() != 0) begin
      rd(8'h08, d);
      check("rx_fifo", d, {24'h0, rx_q[0]});
      wr(8'h0C, 32'h0);
      void'(rx_q.pop_front());
    end
    rd(8'h04, d);
    check("rx_drained", d[2], 0);
    wr(8'h10, 32'h20);
    rd(8'h04, d);
    check("rx_ovf_clr", d[5], 0);
    tx_drain(200);
    mon_off = 1'b1;
    wr(8'h00, 32'h99);
    wr(8'h00, 32'h98);
    tick(10);
    rd(8'h04, d);
    check("mid_busy", d[6], 1);
    rst = 1'b1;
    tick(1);
    check("rst_mid_txd", txd, 1);
    rd(8'h04, d);
    check("rst_mid_status", d, 32'h02);
    check("rst_mid_irq", irq, 0);
    rst = 1'b0;
    seen_low = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (!txd) seen_low = 1'b1;
    end
    check("rst_flush", seen_low, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
